// File: rtl/uart_pkt_pkg.sv
// Shared types and constants for the UART receive packet controller.
package uart_pkt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        PAYLOAD,
        CHECK,
        HOLD
    } pkt_state_t;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_LEN      = 3'd1,
        ERR_CHECKSUM = 3'd2,
        ERR_TIMEOUT  = 3'd3,
        ERR_PARITY   = 3'd4
    } pkt_err_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_pkt_timeout.sv
// Inter-byte timeout counter: synchronous clear, count enable, terminal-count flag.
module uart_pkt_timeout #(
    parameter int unsigned CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc_c
);

    localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [CW-1:0] cnt_q;

    assign tc_c = (cnt_q == CW'(CYCLES - 1));

    // Counter parks at terminal count until cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && !tc_c) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/uart_rx_packet_ctrl.sv
// Frames UART receiver bytes into SYNC/LEN/payload/CHK packets and holds good payloads for the core.
// Optional per-error statistics counters are built when UART_RX_PKT_STATS_EN is defined.
module uart_rx_packet_ctrl
    import uart_pkt_pkg::*;
#(
    parameter int unsigned   MAX_LEN        = 16,
    parameter logic [7:0]    SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int unsigned   TIMEOUT_CYCLES = 1000,
    localparam int unsigned  AW             = $clog2(MAX_LEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    input  logic          rx_parity_err,
    output logic          rx_enable,
    output logic          frame_valid,
    output logic [7:0]    frame_len,
    input  logic          frame_ack,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          frame_err,
    output logic [2:0]    err_code,
    output logic          busy
`ifdef UART_RX_PKT_STATS_EN
    ,
    output logic [7:0]    len_err_cnt,
    output logic [7:0]    chk_err_cnt,
    output logic [7:0]    tmo_err_cnt,
    output logic [7:0]    par_err_cnt,
    output logic [7:0]    ovr_cnt
`endif
);

    pkt_state_t    state_q, state_d;
    pkt_err_t      err_c;
    logic [7:0]    len_q, len_d;
    logic [7:0]    chk_q, chk_d;
    logic [7:0]    frame_len_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          wr_en_c;
    logic          len_ok_c;
    logic          in_pkt_c;
    logic          tmo_tc_c;
    logic [7:0]    mem [MAX_LEN];

    assign len_ok_c = (rx_data != 8'd0) && (32'(rx_data) <= MAX_LEN);
    assign in_pkt_c = (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CHECK);

    uart_pkt_timeout #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk  (clk),
        .rst  (rst),
        .clr  (rx_valid | ~in_pkt_c),
        .en   (in_pkt_c),
        .tc_c (tmo_tc_c)
    );

    // Next state; parity beats a byte, a byte beats the timeout.
    always_comb begin
        state_d     = state_q;
        err_c       = ERR_NONE;
        len_d       = len_q;
        chk_d       = chk_q;
        idx_d       = idx_q;
        frame_len_d = frame_len;
        wr_en_c     = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) state_d = LEN;
            end
            LEN: begin
                if (rx_parity_err) begin
                    err_c = ERR_PARITY;
                end else if (rx_valid) begin
                    if (len_ok_c) begin
                        len_d   = rx_data;
                        chk_d   = rx_data;
                        idx_d   = '0;
                        state_d = PAYLOAD;
                    end else begin
                        err_c = ERR_LEN;
                    end
                end else if (tmo_tc_c) begin
                    err_c = ERR_TIMEOUT;
                end
            end
            PAYLOAD: begin
                if (rx_parity_err) begin
                    err_c = ERR_PARITY;
                end else if (rx_valid) begin
                    wr_en_c = 1'b1;
                    chk_d   = chk_q ^ rx_data;
                    if (8'(idx_q) == (len_q - 8'd1)) begin
                        state_d = CHECK;
                    end else begin
                        idx_d = idx_q + AW'(1);
                    end
                end else if (tmo_tc_c) begin
                    err_c = ERR_TIMEOUT;
                end
            end
            CHECK: begin
                if (rx_parity_err) begin
                    err_c = ERR_PARITY;
                end else if (rx_valid) begin
                    if (rx_data == chk_q) begin
                        state_d     = HOLD;
                        frame_len_d = len_q;
                    end else begin
                        err_c = ERR_CHECKSUM;
                    end
                end else if (tmo_tc_c) begin
                    err_c = ERR_TIMEOUT;
                end
            end
            HOLD: begin
                if (frame_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (err_c != ERR_NONE) state_d = IDLE;
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= 8'd0;
            chk_q       <= 8'd0;
            idx_q       <= '0;
            rx_enable   <= 1'b1;
            frame_valid <= 1'b0;
            frame_len   <= 8'd0;
            frame_err   <= 1'b0;
            err_code    <= 3'd0;
            busy        <= 1'b0;
            rd_data     <= 8'd0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            chk_q       <= chk_d;
            idx_q       <= idx_d;
            rx_enable   <= (state_d != HOLD);
            frame_valid <= (state_d == HOLD);
            frame_len   <= frame_len_d;
            frame_err   <= (err_c != ERR_NONE);
            busy        <= (state_d == LEN) || (state_d == PAYLOAD) || (state_d == CHECK);
            if (err_c != ERR_NONE) err_code <= err_c;
            rd_data     <= mem[rd_addr];
        end
    end

    // Payload buffer; only written in PAYLOAD, so it is frozen while a frame is held.
    always_ff @(posedge clk) begin
        if (wr_en_c) mem[idx_q] <= rx_data;
    end

`ifdef UART_RX_PKT_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_err_cnt <= 8'd0;
            chk_err_cnt <= 8'd0;
            tmo_err_cnt <= 8'd0;
            par_err_cnt <= 8'd0;
            ovr_cnt     <= 8'd0;
        end else begin
            if (err_c == ERR_LEN)              len_err_cnt <= sat_inc8(len_err_cnt);
            if (err_c == ERR_CHECKSUM)         chk_err_cnt <= sat_inc8(chk_err_cnt);
            if (err_c == ERR_TIMEOUT)          tmo_err_cnt <= sat_inc8(tmo_err_cnt);
            if (err_c == ERR_PARITY)           par_err_cnt <= sat_inc8(par_err_cnt);
            if (state_q == HOLD && rx_valid)   ovr_cnt     <= sat_inc8(ovr_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_packet_ctrl.sv
// Randomized self-checking bench for uart_rx_packet_ctrl against a packet-level reference model.
module tb_uart_rx_packet_ctrl;

    localparam int unsigned MAX_LEN = 16;
    localparam int unsigned TO      = 64;
    localparam int unsigned AW      = $clog2(MAX_LEN);

    typedef logic [7:0] bq_t[$];

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    rx_data = 8'd0;
    logic          rx_valid = 1'b0;
    logic          rx_parity_err = 1'b0;
    logic          frame_ack = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rx_enable, frame_valid, frame_err, busy;
    logic [7:0]    frame_len, rd_data;
    logic [2:0]    err_code;
`ifdef UART_RX_PKT_STATS_EN
    logic [7:0]    len_err_cnt, chk_err_cnt, tmo_err_cnt, par_err_cnt, ovr_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int exp_cnt[5] = '{0, 0, 0, 0, 0};   // index = err code; [0] counts overruns
    bq_t held;

    uart_rx_packet_ctrl #(
        .MAX_LEN        (MAX_LEN),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_parity_err (rx_parity_err),
        .rx_enable     (rx_enable),
        .frame_valid   (frame_valid),
        .frame_len     (frame_len),
        .frame_ack     (frame_ack),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .frame_err     (frame_err),
        .err_code      (err_code),
        .busy          (busy)
`ifdef UART_RX_PKT_STATS_EN
        ,
        .len_err_cnt   (len_err_cnt),
        .chk_err_cnt   (chk_err_cnt),
        .tmo_err_cnt   (tmo_err_cnt),
        .par_err_cnt   (par_err_cnt),
        .ovr_cnt       (ovr_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // One bus cycle of receiver activity; returns on the negedge after it was sampled.
    task automatic drive(input logic [7:0] b, input logic v, input logic p);
        @(negedge clk);
        rx_data = b; rx_valid = v; rx_parity_err = p;
        @(negedge clk);
        rx_valid = 1'b0; rx_parity_err = 1'b0;
    endtask

    function automatic bq_t make_pkt(input bq_t pl, input logic [7:0] chk_flip);
        bq_t q;
        logic [7:0] c;
        c = 8'(pl.size());
        q.push_back(8'hA5);
        q.push_back(c);
        foreach (pl[i]) begin
            q.push_back(pl[i]);
            c = c ^ pl[i];
        end
        q.push_back(c ^ chk_flip);
        return q;
    endfunction

    function automatic bq_t rand_payload(input int n);
        bq_t pl;
        for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
        return pl;
    endfunction

    // Packet-level reference: expected error code and the byte index where the outcome appears.
    function automatic int model_outcome(input bq_t q, output int end_idx);
        int l;
        logic [7:0] c;
        l = int'(q[1]);
        if (l == 0 || l > int'(MAX_LEN)) begin
            end_idx = 1;
            return 1;
        end
        c = 8'd0;
        for (int i = 1; i <= l + 1; i++) c = c ^ q[i];
        end_idx = l + 2;
        return (q[l + 2] == c) ? 0 : 2;
    endfunction

    task automatic read_back(input string tag);
        for (int i = 0; i < held.size(); i++) begin
            @(negedge clk);
            rd_addr = AW'(i);
            @(negedge clk);
            check(tag, rd_data, held[i]);
        end
    endtask

    task automatic ack_frame();
        @(negedge clk);
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        check("ack_fv", frame_valid, 0);
        check("ack_en", rx_enable, 1);
    endtask

    task automatic run_pkt(input bq_t q, input int par_at, input bit par_with, input int ovr_n);
        int e, end_idx;
        e = model_outcome(q, end_idx);
        if (par_at > 0 && par_at <= end_idx) begin
            e = 4;
            end_idx = par_at;
        end
        for (int i = 0; i <= end_idx; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if (i == par_at) drive(q[i], par_with, 1'b1);
            else             drive(q[i], 1'b1, 1'b0);
            if (i < end_idx) begin
                check("mid_err", frame_err, 0);
                check("mid_busy", busy, 1);
            end
        end
        check("err_pulse", frame_err, (e != 0) ? 1 : 0);
        if (e != 0) check("err_code", err_code, e);
        check("end_busy", busy, 0);
        check("frame_valid", frame_valid, (e == 0) ? 1 : 0);
        if (e != 0) exp_cnt[e]++;
        @(negedge clk);
        check("err_1cyc", frame_err, 0);
        if (e == 0) begin
            held = q[2 : q.size() - 2];
            check("frame_len", frame_len, held.size());
            check("hold_en", rx_enable, 0);
            read_back("rd_data");
            if (ovr_n > 0) begin
                for (int k = 0; k < ovr_n; k++) drive(8'($urandom), 1'b1, 1'b0);
                exp_cnt[0] += ovr_n;
                check("ovr_fv", frame_valid, 1);
                read_back("ovr_rd");
            end
            ack_frame();
        end
    endtask

    initial begin
        bq_t q;
        int k;

        #12;
        check("rst_en", rx_enable, 1);
        check("rst_fv", frame_valid, 0);
        check("rst_err", frame_err, 0);
        check("rst_busy", busy, 0);
        check("rst_len", frame_len, 0);
        check("rst_code", err_code, 0);
        check("rst_rd", rd_data, 0);
        @(negedge clk);
        rst = 1'b0;

        // Good 3-byte frame, bad checksum, both illegal lengths.
        q = make_pkt('{8'h11, 8'h22, 8'h33}, 8'h00);
        run_pkt(q, -1, 1'b0, 0);
        run_pkt('{8'hA5, 8'h02, 8'h10, 8'h20, 8'h31}, -1, 1'b0, 0);
        run_pkt('{8'hA5, 8'h00}, -1, 1'b0, 0);
        run_pkt('{8'hA5, 8'(MAX_LEN + 1)}, -1, 1'b0, 0);
        // Full-size frame with overrun bytes while held.
        run_pkt(make_pkt(rand_payload(MAX_LEN), 8'h00), -1, 1'b0, 3);

        // Silence mid-payload until the inter-byte timeout fires.
        drive(8'hA5, 1'b1, 1'b0);
        drive(8'h02, 1'b1, 1'b0);
        drive(8'h10, 1'b1, 1'b0);
        k = 0;
        while (!frame_err && k < int'(2 * TO)) begin
            @(negedge clk);
            k++;
        end
        check("tmo_cycles", k, TO);
        check("tmo_code", err_code, 3);
        exp_cnt[3]++;
        @(negedge clk);
        check("tmo_busy", busy, 0);
        run_pkt(make_pkt('{8'h5A, 8'hC3}, 8'h00), -1, 1'b0, 0);

        // Parity alone in LEN, then parity together with a payload byte.
        run_pkt('{8'hA5, 8'h02, 8'h10, 8'h20, 8'h32}, 1, 1'b0, 0);
        run_pkt('{8'hA5, 8'h02, 8'h10, 8'h20, 8'h32}, 3, 1'b1, 0);

        // Randomized packets with garbage, bad checksums, bad lengths and parity hits.
        for (int n = 0; n < 40; n++) begin
            int kind, par_at;
            logic [7:0] g;
            repeat ($urandom_range(0, 2)) begin
                g = 8'($urandom);
                if (g == 8'hA5) g = 8'h5A;
                drive(g, 1'b1, 1'b0);
                check("garbage_busy", busy, 0);
            end
            kind = $urandom_range(0, 4);
            par_at = -1;
            case (kind)
                2: q = make_pkt(rand_payload($urandom_range(1, MAX_LEN)), 8'($urandom_range(1, 255)));
                3: q = '{8'hA5, ($urandom_range(0, 1) != 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255))};
                default: q = make_pkt(rand_payload($urandom_range(1, MAX_LEN)), 8'h00);
            endcase
            if (kind == 4) par_at = $urandom_range(1, q.size() - 1);
            run_pkt(q, par_at, 1'($urandom_range(0, 1)), (kind == 0) ? int'($urandom_range(0, 2)) : 0);
        end

`ifdef UART_RX_PKT_STATS_EN
        check("len_err_cnt", len_err_cnt, exp_cnt[1]);
        check("chk_err_cnt", chk_err_cnt, exp_cnt[2]);
        check("tmo_err_cnt", tmo_err_cnt, exp_cnt[3]);
        check("par_err_cnt", par_err_cnt, exp_cnt[4]);
        check("ovr_cnt", ovr_cnt, exp_cnt[0]);
`endif

        // Reset in the middle of a payload: no error, outputs back to reset values.
        drive(8'hA5, 1'b1, 1'b0);
        drive(8'h04, 1'b1, 1'b0);
        drive(8'h11, 1'b1, 1'b0);
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("mrst_busy", busy, 0);
        check("mrst_err", frame_err, 0);
        check("mrst_en", rx_enable, 1);
        check("mrst_len", frame_len, 0);
        check("mrst_code", err_code, 0);
        check("mrst_rd", rd_data, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_err", frame_err, 0);
        end
        run_pkt(make_pkt(rand_payload(5), 8'h00), -1, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
